// File: rtl/serial_subtractor_if.sv
// Start/ready/done request bus for the bit-serial subtractor.
interface serial_subtractor_if #(
  parameter int W = 8
);
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         overflow;

  modport master (
    output start, a, b,
    input  ready, done, diff, borrow_out, overflow
  );

  modport slave (
    input  start, a, b,
    output ready, done, diff, borrow_out, overflow
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first a - b using one full-subtractor cell; done pulses W+1 cycles after accept.
// start is ignored while ready is low (not queued); results hold until the completing edge.
module serial_subtractor #(
  parameter int W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);
  localparam int CW = $clog2(W) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t         state;
  state_t         state_nx;
  logic [W-1:0]   a_sh;
  logic [W-1:0]   b_sh;
  logic [W-1:0]   p_sh;
  logic [W-1:0]   diff_q;
  logic [CW-1:0]  cnt;
  logic           bor;
  logic           a_msb;
  logic           b_msb;
  logic           borrow_q;
  logic           ovf_q;
  logic           done_q;
  logic           ready_q;

  logic           x;
  logic           y;
  logic           d;
  logic           bor_nx;
  logic           last;

  assign x      = a_sh[0];
  assign y      = b_sh[0];
  assign d      = x ^ y ^ bor;
  assign bor_nx = (~x & y) | (~x & bor) | (y & bor);
  assign last   = (cnt == CW'(W - 1));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = SHIFT;
      SHIFT:   if (last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // ready/done are registered off the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      p_sh     <= '0;
      diff_q   <= '0;
      cnt      <= '0;
      bor      <= 1'b0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      done_q  <= (state_nx == DONE);
      ready_q <= (state_nx == IDLE);
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sh  <= bus.a;
            b_sh  <= bus.b;
            bor   <= 1'b0;
            cnt   <= '0;
            a_msb <= bus.a[W-1];
            b_msb <= bus.b[W-1];
          end
        end
        SHIFT: begin
          a_sh <= {1'b0, a_sh[W-1:1]};
          b_sh <= {1'b0, b_sh[W-1:1]};
          p_sh <= {d, p_sh[W-1:1]};
          bor  <= bor_nx;
          cnt  <= cnt + CW'(1);
          if (last) begin
            diff_q   <= {d, p_sh[W-1:1]};
            borrow_q <= bor_nx;
            ovf_q    <= (a_msb != b_msb) & (d != a_msb);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready      = ready_q;
  assign bus.done       = done_q;
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_q;
  assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench: W=8 directed + random ops, W=5 random ops, against an integer model.
module tb_serial_subtractor;
  typedef struct {
    logic [7:0] d;
    logic       bo;
    logic       ov;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  exp_t q8[$];
  exp_t q5[$];
  exp_t last8;
  exp_t last5;

  serial_subtractor_if #(.W(8)) bus8 ();
  serial_subtractor_if #(.W(5)) bus5 ();

  serial_subtractor #(.W(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_subtractor #(.W(5)) u5 (.clk(clk), .rst_n(rst_n), .bus(bus5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: signed/unsigned integer arithmetic on w-bit operands.
  function automatic exp_t model(input int w, input int unsigned av, input int unsigned bv);
    exp_t        e;
    int unsigned m;
    int          sa;
    int          sb;
    int          sd;
    m    = 32'd1 << w;
    e.d  = 8'((av + m - bv) % m);
    e.bo = (av < bv);
    sa   = (av >= m / 2) ? int'(av) - int'(m) : int'(av);
    sb   = (bv >= m / 2) ? int'(bv) - int'(m) : int'(bv);
    sd   = sa - sb;
    e.ov = (sd < -int'(m / 2)) || (sd >= int'(m / 2));
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      last8 = '{8'h00, 1'b0, 1'b0};
    end else if (bus8.done) begin
      n_cmp++;
      if (q8.size() == 0) begin
        n_err++;
        $display("FAIL done8_unexpected: got done with empty queue at %0t", $time);
      end else begin
        last8 = q8.pop_front();
        chk("diff8", bus8.diff, last8.d);
        chk("borrow8", bus8.borrow_out, last8.bo);
        chk("ovf8", bus8.overflow, last8.ov);
      end
    end else begin
      chk("hold_diff8", bus8.diff, last8.d);
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      last5 = '{8'h00, 1'b0, 1'b0};
    end else if (bus5.done) begin
      n_cmp++;
      if (q5.size() == 0) begin
        n_err++;
        $display("FAIL done5_unexpected: got done with empty queue at %0t", $time);
      end else begin
        last5 = q5.pop_front();
        chk("diff5", {3'b000, bus5.diff}, last5.d);
        chk("borrow5", bus5.borrow_out, last5.bo);
        chk("ovf5", bus5.overflow, last5.ov);
      end
    end else begin
      chk("hold_diff5", {3'b000, bus5.diff}, last5.d);
    end
  end

  task automatic wait_ready8();
    int n = 0;
    while (!bus8.ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ready8_timeout", bus8.ready, 1'b1);
  endtask

  task automatic wait_ready5();
    int n = 0;
    while (!bus5.ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ready5_timeout", bus5.ready, 1'b1);
  endtask

  // One W=8 operation with cycle-exact done/ready checks; optional ignored
  // start at cycle 'interfere' or async reset at cycle 'rst_at'.
  task automatic op8(input logic [7:0] av, input logic [7:0] bv,
                     input int interfere, input int rst_at);
    wait_ready8();
    bus8.start = 1'b1;
    bus8.a     = av;
    bus8.b     = bv;
    q8.push_back(model(8, av, bv));
    @(posedge clk);
    #1;
    bus8.start = 1'b0;
    bus8.a     = 8'($urandom);
    bus8.b     = 8'($urandom);
    for (int j = 1; j <= 9; j++) begin
      @(posedge clk);
      @(negedge clk);
      if (j == rst_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ready", bus8.ready, 1'b1);
        chk("rst_done", bus8.done, 1'b0);
        chk("rst_diff", bus8.diff, 8'h00);
        chk("rst_borrow", bus8.borrow_out, 1'b0);
        chk("rst_ovf", bus8.overflow, 1'b0);
        q8.delete();
        last8 = '{8'h00, 1'b0, 1'b0};
        last5 = '{8'h00, 1'b0, 1'b0};
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        break;
      end
      chk("done8_timing", bus8.done, (j == 8));
      chk("ready8_timing", bus8.ready, (j == 9));
      if (j == interfere) begin
        bus8.start = 1'b1;
        bus8.a     = 8'hFF;
        bus8.b     = 8'h00;
      end
      if (j == interfere + 1) bus8.start = 1'b0;
    end
  endtask

  task automatic op5(input logic [4:0] av, input logic [4:0] bv);
    wait_ready5();
    bus5.start = 1'b1;
    bus5.a     = av;
    bus5.b     = bv;
    q5.push_back(model(5, av, bv));
    @(posedge clk);
    #1;
    bus5.start = 1'b0;
    bus5.a     = 5'($urandom);
    bus5.b     = 5'($urandom);
  endtask

  initial begin
    int n;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus8.start = 1'b0;
    bus8.a     = '0;
    bus8.b     = '0;
    bus5.start = 1'b0;
    bus5.a     = '0;
    bus5.b     = '0;
    repeat (3) @(negedge clk);
    chk("reset_ready", bus8.ready, 1'b1);
    chk("reset_done", bus8.done, 1'b0);
    chk("reset_diff", bus8.diff, 8'h00);
    chk("reset_borrow", bus8.borrow_out, 1'b0);
    chk("reset_ovf", bus8.overflow, 1'b0);
    chk("reset_ready5", bus5.ready, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);

    op8(8'h35, 8'h12, 0, 0);
    op8(8'h12, 8'h35, 0, 0);
    op8(8'h80, 8'h01, 0, 0);
    op8(8'h7F, 8'hFF, 0, 0);
    op8(8'h00, 8'h00, 0, 0);
    op8(8'h00, 8'h01, 0, 0);
    op8(8'h35, 8'h12, 3, 0);
    op8(8'h35, 8'h12, 0, 4);
    op8(8'hA0, 8'h0A, 0, 0);
    op8(8'hFF, 8'hFF, 0, 0);
    op8(8'h7F, 8'h80, 0, 0);
    for (int i = 0; i < 30; i++) op8(8'($urandom), 8'($urandom), 0, 0);
    for (int i = 0; i < 30; i++) op5(5'($urandom), 5'($urandom));
    op5(5'h10, 5'h01);
    op5(5'h0F, 5'h1F);

    n = 0;
    while ((q5.size() != 0 || q8.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_q8", q8.size(), 0);
    chk("drain_q5", q5.size(), 0);
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial, LSB-first two's-complement subtractor computing diff = a - b over W cycles.
- It reuses a single full-subtractor cell (the inverse operation of the full-adder cell) with a registered borrow flip-flop.
- Sits in the combinational/arithmetic library as the area-minimal subtract path, with a start/ready/done handshake for use by sequencing logic.

Parameters:
- W, 8, operand and result width in bits; legal range W >= 2.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a subtraction; accepted only when ready=1
- a  input  W  minuend; sampled on the accepting edge only
- b  input  W  subtrahend; sampled on the accepting edge only
- ready  output  1  high in IDLE; block can accept start
- done  output  1  one-cycle pulse; result outputs are valid and freshly updated
- diff  output  W  a - b modulo 2^W
- borrow_out  output  1  unsigned borrow; 1 iff a < b (unsigned)
- overflow  output  1  signed overflow of a - b

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. clk and rst_n are the only clock and reset.
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - ready=1, done=0, diff=0, borrow_out=0, overflow=0.
  - Internal shift registers, borrow flip-flop and bit counter are cleared.
- A reset asserted mid-operation aborts the operation. No done is produced, and the result outputs read 0.
- States: IDLE, SHIFT, DONE. All outputs are registered.
- IDLE:
  - ready=1.
  - On an edge with start=1: load a_sh<=a, b_sh<=b, bor<=0, cnt<=0, latch the a and b MSBs for the overflow calculation, go to SHIFT.
  - On an edge with start=0: remain in IDLE.
- SHIFT (W cycles):
  - ready=0.
  - Each edge processes bit i = cnt using x = a_sh[0], y = b_sh[0]:
    - d = x ^ y ^ bor.
    - bor <= (~x & y) | (~x & bor) | (y & bor).
    - a_sh and b_sh shift right by 1.
    - d enters the MSB of the partial-difference register, which shifts right.
    - cnt <= cnt + 1.
  - On the edge where cnt == W-1 (final bit):
    - diff <= completed partial register including d.
    - borrow_out <= final borrow.
    - overflow <= (a_msb != b_msb) & (d != a_msb).
    - done <= 1; go to DONE.
- DONE (1 cycle):
  - done=1, ready=0.
  - Next edge: done<=0, go to IDLE.
- Latency and throughput:
  - start accepted at edge k → done high during the cycle following edge k+W.
  - ready returns high after edge k+W+1.
  - Throughput is one operation per W+2 cycles minimum.
- Result hold: diff, borrow_out and overflow hold the previous result throughout SHIFT. They change only on the completing edge. Partial values are never visible.
- start while ready=0 (SHIFT or DONE) is ignored entirely. It is not queued and must not disturb the operands.
- a and b may change freely after the accepting edge.
- cnt width is clog2(W)+1; no wrap occurs within an operation.
- Arithmetic rules: diff equals (a - b) mod 2^W for all inputs. borrow_out equals unsigned a < b. overflow is set only when the operand signs differ and the result sign differs from the sign of a.

Test Plan:
- Reset → ready=1, done=0, diff=0x00, borrow_out=0, overflow=0. Start at edge k with a=0x35, b=0x12 → done pulses exactly in the cycle after edge k+8 for one cycle; diff=0x23, borrow_out=0, overflow=0.
- a=0x12, b=0x35 → diff=0xDD, borrow_out=1, overflow=0.
- a=0x80, b=0x01 → diff=0x7F, borrow_out=0, overflow=1. Then a=0x7F, b=0xFF → diff=0x80, borrow_out=1, overflow=1.
- a=0x00, b=0x00 → diff=0x00, borrow_out=0, overflow=0. Then a=0x00, b=0x01 → diff=0xFF, borrow_out=1, overflow=0.
- Start a=0x35, b=0x12; at cycle 3 assert start with a=0xFF, b=0x00 and change the a/b pins → second start ignored; result 0x23, exactly one done pulse. Between done and completion of the next operation, diff holds 0x23.
- Start a=0x35, b=0x12; pull rst_n low at cycle 4 (asynchronously, mid-cycle) → outputs clear immediately, no done pulse. After release, a=0xA0, b=0x0A completes with diff=0x96, borrow_out=0, overflow=0. Also run randomized W=8 and W=5 checks against a reference model.
